// File: rtl/fio_init_sequencer.sv
// Host-side FileIO sequencer: streams an init image into the GPU, runs it,
// waits for completion (with timeout) and dumps data memory.
module fio_init_sequencer #(
  parameter int MEM_SIZE       = 256,
  parameter int SHMEM_SIZE     = 256,
  parameter int ICACHE_DEPTH   = 4096,
  parameter int TM_DEPTH       = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW  = $clog2(MEM_SIZE + SHMEM_SIZE),
  localparam int MAW = $clog2(MEM_SIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  output logic           busy,
  output logic           done,
  output logic           timeout_err,
  output logic [31:0]    run_cycles,
  output logic           img_rd_en,
  output logic [1:0]     img_sel,
  output logic [11:0]    img_addr,
  input  logic [255:0]   img_rdata,
  output logic           Write_Enable_FIO_TM,
  output logic [28:0]    Write_Data_FIO_TM,
  output logic           start_FIO_TM,
  output logic           clear_FIO_TM,
  input  logic           finished_TM_FIO,
  output logic           FileIO_Wen_ICache,
  output logic [11:0]    FileIO_Addr_ICache,
  output logic [31:0]    FileIO_Din_ICache,
  output logic           FIO_MEMWRITE,
  output logic [AW-1:0]  FIO_ADDR,
  output logic [255:0]   FIO_WRITE_DATA,
  input  logic [255:0]   FIO_READ_DATA,
  output logic           FIO_CACHE_LAT_WRITE,
  output logic [4:0]     FIO_CACHE_LAT_VALUE,
  output logic [MAW-1:0] FIO_CACHE_MEM_ADDR,
  output logic           dump_valid,
  output logic [MAW-1:0] dump_addr,
  output logic [255:0]   dump_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_LD_TM, S_LD_IC, S_LD_MEM, S_LD_LAT,
    S_START, S_WAIT, S_DUMP, S_DONE
  } state_t;

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  state_t         state_q, state_d;
  logic [12:0]    cnt_q, cnt_d;
  logic [31:0]    run_q, run_d;
  logic           to_q, to_d;

  logic [28:0]    tmd_q, tmd_d;
  logic [11:0]    ica_q, ica_d;
  logic [31:0]    icd_q, icd_d;
  logic [AW-1:0]  fa_q, fa_d;
  logic [255:0]   fwd_q, fwd_d;
  logic [4:0]     latv_q, latv_d;
  logic [MAW-1:0] lata_q, lata_d;
  logic [MAW-1:0] dpa_q, dpa_d;
  logic [255:0]   dpd_q, dpd_d;

  function automatic logic [12:0] phase_len(input state_t s);
    case (s)
      S_LD_TM:  return 13'(TM_DEPTH);
      S_LD_IC:  return 13'(ICACHE_DEPTH);
      S_LD_MEM: return 13'(MEM_SIZE);
      S_LD_LAT: return 13'(MEM_SIZE);
      default:  return 13'd0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [12:0] n_words;
  logic [11:0] wa;
  logic        rd_ok;
  logic        wr_ok;
  logic [31:0] run_inc;

  // Word i is read in cycle i and written in cycle i+1, so the write index lags by one.
  assign n_words = phase_len(state_q);
  assign wa      = 12'(cnt_q - 13'd1);
  assign rd_ok   = (cnt_q != n_words);
  assign wr_ok   = (cnt_q != 13'd0);
  assign run_inc = sat_inc(run_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      to_q    <= 1'b0;
      tmd_q   <= '0;
      ica_q   <= '0;
      icd_q   <= '0;
      fa_q    <= '0;
      fwd_q   <= '0;
      latv_q  <= '0;
      lata_q  <= '0;
      dpa_q   <= '0;
      dpd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      to_q    <= to_d;
      tmd_q   <= tmd_d;
      ica_q   <= ica_d;
      icd_q   <= icd_d;
      fa_q    <= fa_d;
      fwd_q   <= fwd_d;
      latv_q  <= latv_d;
      lata_q  <= lata_d;
      dpa_q   <= dpa_d;
      dpd_q   <= dpd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_CLR;
      S_CLR: begin
        cnt_d   = '0;
        run_d   = '0;
        to_d    = 1'b0;
        state_d = S_LD_TM;
      end
      S_LD_TM, S_LD_IC, S_LD_MEM, S_LD_LAT: begin
        if (!rd_ok) begin
          cnt_d = '0;
          case (state_q)
            S_LD_TM:  state_d = S_LD_IC;
            S_LD_IC:  state_d = S_LD_MEM;
            S_LD_MEM: state_d = S_LD_LAT;
            default:  state_d = S_START;
          endcase
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_START: begin
        run_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = '0;
        // The cycle finished_TM_FIO is seen does not count toward run time.
        if (finished_TM_FIO) begin
          state_d = S_DUMP;
        end else begin
          run_d = run_inc;
          if (run_inc >= TO_LIM) begin
            to_d    = 1'b1;
            state_d = S_DUMP;
          end
        end
      end
      S_DUMP: begin
        if (cnt_q == 13'(MEM_SIZE)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      S_DONE: if (go) state_d = S_CLR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    img_rd_en           = 1'b0;
    img_sel             = 2'd0;
    img_addr            = '0;
    Write_Enable_FIO_TM = 1'b0;
    start_FIO_TM        = 1'b0;
    clear_FIO_TM        = 1'b0;
    FileIO_Wen_ICache   = 1'b0;
    FIO_MEMWRITE        = 1'b0;
    FIO_CACHE_LAT_WRITE = 1'b0;
    dump_valid          = 1'b0;
    tmd_d  = tmd_q;
    ica_d  = ica_q;
    icd_d  = icd_q;
    fa_d   = fa_q;
    fwd_d  = fwd_q;
    latv_d = latv_q;
    lata_d = lata_q;
    dpa_d  = dpa_q;
    dpd_d  = dpd_q;
    case (state_q)
      S_CLR: clear_FIO_TM = 1'b1;
      S_LD_TM, S_LD_IC, S_LD_MEM, S_LD_LAT: begin
        img_rd_en = rd_ok;
        img_addr  = rd_ok ? cnt_q[11:0] : 12'd0;
        case (state_q)
          S_LD_TM: begin
            img_sel             = 2'd0;
            Write_Enable_FIO_TM = wr_ok;
            if (wr_ok) tmd_d = img_rdata[28:0];
          end
          S_LD_IC: begin
            img_sel           = 2'd1;
            FileIO_Wen_ICache = wr_ok;
            if (wr_ok) begin
              ica_d = wa;
              icd_d = img_rdata[31:0];
            end
          end
          S_LD_MEM: begin
            img_sel      = 2'd2;
            FIO_MEMWRITE = wr_ok;
            if (wr_ok) begin
              fa_d  = {{(AW-MAW){1'b0}}, wa[MAW-1:0]};
              fwd_d = img_rdata;
            end
          end
          default: begin
            img_sel             = 2'd3;
            FIO_CACHE_LAT_WRITE = wr_ok;
            if (wr_ok) begin
              lata_d = wa[MAW-1:0];
              latv_d = img_rdata[4:0];
            end
          end
        endcase
      end
      S_START: start_FIO_TM = 1'b1;
      S_DUMP: begin
        // Read address leads the returned data by one cycle.
        if (cnt_q < 13'(MEM_SIZE)) fa_d = {{(AW-MAW){1'b0}}, cnt_q[MAW-1:0]};
        if (wr_ok) begin
          dump_valid = 1'b1;
          dpa_d      = wa[MAW-1:0];
          dpd_d      = FIO_READ_DATA;
        end
      end
      default: ;
    endcase
  end

  assign busy                = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done                = (state_q == S_DONE);
  assign timeout_err         = to_q;
  assign run_cycles          = run_q;
  assign Write_Data_FIO_TM   = tmd_d;
  assign FileIO_Addr_ICache  = ica_d;
  assign FileIO_Din_ICache   = icd_d;
  assign FIO_ADDR            = fa_d;
  assign FIO_WRITE_DATA      = fwd_d;
  assign FIO_CACHE_LAT_VALUE = latv_d;
  assign FIO_CACHE_MEM_ADDR  = lata_d;
  assign dump_addr           = dpa_d;
  assign dump_data           = dpd_d;

endmodule

// File: tb/tb_fio_init_sequencer.sv
// Directed bench for fio_init_sequencer: image/memory models, write monitors,
// and a second instance with a short timeout.
module tb_fio_init_sequencer;
  localparam int AW  = 9;
  localparam int MAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go, go2;
  int n_cmp = 0;
  int n_err = 0;

  // Main instance
  logic busy, done, timeout_err, img_rd_en;
  logic [31:0] run_cycles;
  logic [1:0] img_sel;
  logic [11:0] img_addr;
  logic [255:0] img_rdata = '0;
  logic we_tm, start_tm, clear_tm;
  logic finished = 1'b0;
  logic [28:0] wd_tm;
  logic ic_wen;
  logic [11:0] ic_addr;
  logic [31:0] ic_din;
  logic memwrite;
  logic [AW-1:0] fio_addr;
  logic [255:0] fio_wdata;
  logic [255:0] fio_rdata = '0;
  logic lat_we;
  logic [4:0] lat_val;
  logic [MAW-1:0] lat_addr;
  logic dv;
  logic [MAW-1:0] da;
  logic [255:0] dd;

  fio_init_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .timeout_err(timeout_err), .run_cycles(run_cycles),
    .img_rd_en(img_rd_en), .img_sel(img_sel), .img_addr(img_addr), .img_rdata(img_rdata),
    .Write_Enable_FIO_TM(we_tm), .Write_Data_FIO_TM(wd_tm),
    .start_FIO_TM(start_tm), .clear_FIO_TM(clear_tm), .finished_TM_FIO(finished),
    .FileIO_Wen_ICache(ic_wen), .FileIO_Addr_ICache(ic_addr), .FileIO_Din_ICache(ic_din),
    .FIO_MEMWRITE(memwrite), .FIO_ADDR(fio_addr), .FIO_WRITE_DATA(fio_wdata),
    .FIO_READ_DATA(fio_rdata),
    .FIO_CACHE_LAT_WRITE(lat_we), .FIO_CACHE_LAT_VALUE(lat_val), .FIO_CACHE_MEM_ADDR(lat_addr),
    .dump_valid(dv), .dump_addr(da), .dump_data(dd)
  );

  // Short-timeout instance; finished_TM_FIO never rises
  logic busy2, done2, to2, rd2, we2, st2, cl2, icw2, mw2, lw2, dv2;
  logic [31:0] run2;
  logic [1:0] sel2;
  logic [11:0] ia2, ica2;
  logic [255:0] ird2 = '0;
  logic [255:0] frd2 = '0;
  logic fin2 = 1'b0;
  logic [28:0] wd2;
  logic [31:0] icd2;
  logic [AW-1:0] fa2;
  logic [255:0] fwd2, dd2;
  logic [4:0] lv2;
  logic [MAW-1:0] la2, da2;

  fio_init_sequencer #(.ICACHE_DEPTH(16), .TIMEOUT_CYCLES(50)) dut2 (
    .clk(clk), .rst(rst), .go(go2), .busy(busy2), .done(done2),
    .timeout_err(to2), .run_cycles(run2),
    .img_rd_en(rd2), .img_sel(sel2), .img_addr(ia2), .img_rdata(ird2),
    .Write_Enable_FIO_TM(we2), .Write_Data_FIO_TM(wd2),
    .start_FIO_TM(st2), .clear_FIO_TM(cl2), .finished_TM_FIO(fin2),
    .FileIO_Wen_ICache(icw2), .FileIO_Addr_ICache(ica2), .FileIO_Din_ICache(icd2),
    .FIO_MEMWRITE(mw2), .FIO_ADDR(fa2), .FIO_WRITE_DATA(fwd2),
    .FIO_READ_DATA(frd2),
    .FIO_CACHE_LAT_WRITE(lw2), .FIO_CACHE_LAT_VALUE(lv2), .FIO_CACHE_MEM_ADDR(la2),
    .dump_valid(dv2), .dump_addr(da2), .dump_data(dd2)
  );

  // Image contents carry junk above the field each target keeps.
  function automatic logic [255:0] img_word(input logic [1:0] sel, input logic [11:0] a);
    case (sel)
      2'd0:    return {224'h0, 32'hE000_0000 | (32'h1000_0000 + 32'(a))};
      2'd1:    return {224'h55, 32'(a) * 32'd3};
      2'd2:    return {8{32'hC0DE_0000 | 32'(a)}};
      default: return {128'hFFFF, 116'h0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= img_word(img_sel, img_addr);
    if (rd2) ird2 <= img_word(sel2, ia2);
    fio_rdata <= 256'(fio_addr);
    frd2 <= 256'(fa2);
  end

  // finished_TM_FIO rises in the 101st WAIT cycle, so 100 cycles are counted.
  int fin_cnt = 0;
  always @(negedge clk) begin
    if (start_tm) fin_cnt = 1;
    else if (fin_cnt != 0 && fin_cnt < 1000) fin_cnt++;
    finished = (fin_cnt >= 102);
  end

  int cyc = 0, clr_cnt = 0, clr_cyc = 0, multi = 0;
  int tm_idx = 0, tm_cnt = 0, tm_bad = 0, tm_first = 0, tm_last = 0;
  int ic_idx = 0, ic_cnt = 0, ic_bad = 0, ic_span = 0;
  int mem_idx = 0, mem_cnt = 0, mem_bad = 0;
  int lat_idx = 0, lat_cnt = 0, lat_bad = 0, lat255 = 0;
  int dump_idx = 0, dump_cnt = 0, dump_bad = 0, dump2_cnt = 0;
  logic tm_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (clear_tm) begin
      clr_cnt++; clr_cyc = cyc;
      tm_idx = 0; ic_idx = 0; mem_idx = 0; lat_idx = 0; dump_idx = 0;
    end
    if (int'(we_tm) + int'(ic_wen) + int'(memwrite) + int'(lat_we) > 1) multi++;
    if (we_tm) begin
      if (wd_tm !== 29'(32'h1000_0000 + 32'(tm_idx))) tm_bad++;
      if (!tm_prev) tm_first = cyc;
      tm_last = cyc; tm_idx++; tm_cnt++;
    end
    tm_prev = we_tm;
    if (ic_wen) begin
      if (ic_addr !== 12'(ic_idx) || ic_din !== 32'(ic_idx * 3)) ic_bad++;
      ic_idx++; ic_cnt++;
    end
    if ((img_rd_en && img_sel == 2'd1) || ic_wen) ic_span++;
    if (memwrite) begin
      if (fio_addr !== AW'(mem_idx) || fio_wdata !== {8{32'hC0DE_0000 | 32'(mem_idx)}}) mem_bad++;
      mem_idx++; mem_cnt++;
    end
    if (lat_we) begin
      if (lat_addr !== MAW'(lat_idx) || lat_val !== 5'(lat_idx)) lat_bad++;
      if (lat_addr == 8'd255) lat255 = int'(lat_val);
      lat_idx++; lat_cnt++;
    end
    if (dv) begin
      if (da !== MAW'(dump_idx) || dd !== 256'(da)) dump_bad++;
      dump_idx++; dump_cnt++;
    end
    if (dv2) dump2_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  int s_clr, s_tm, s_tmb, s_ic, s_icb, s_span, s_mem, s_memb, s_lat, s_latb, s_dmp, s_dmpb;

  task automatic snap();
    s_clr = clr_cnt; s_tm = tm_cnt; s_tmb = tm_bad; s_ic = ic_cnt; s_icb = ic_bad;
    s_span = ic_span; s_mem = mem_cnt; s_memb = mem_bad; s_lat = lat_cnt; s_latb = lat_bad;
    s_dmp = dump_cnt; s_dmpb = dump_bad;
  endtask

  initial begin
    rst = 1'b0; go = 1'b0; go2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_run", run_cycles, 0);
    check("rst_strobes", {img_rd_en, we_tm, ic_wen, memwrite, lat_we, start_tm, clear_tm, dv}, 0);
    check("rst_addr", fio_addr, 0);
    @(negedge clk) rst = 1'b1;

    // Abort with reset while MEM word 10 is being written
    pulse_go();
    for (int i = 0; i < 6000 && !(memwrite && fio_addr == 9'd10); i++) @(negedge clk);
    check("reach_mem10", {memwrite, fio_addr}, {1'b1, 9'd10});
    rst = 1'b0;
    #1;
    check("abort_strobes", {img_rd_en, we_tm, ic_wen, memwrite, lat_we, start_tm, clear_tm, dv}, 0);
    check("abort_busy_done", {busy, done}, 0);
    check("abort_addr", fio_addr, 0);
    snap();
    @(negedge clk) rst = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_writes", (mem_cnt - s_mem) + (lat_cnt - s_lat) + (tm_cnt - s_tm), 0);
    check("abort_idle", busy, 0);

    // Full run; go pulsed during DUMP must be ignored
    snap();
    pulse_go();
    for (int i = 0; i < 8000 && !dv; i++) @(negedge clk);
    check("reach_dump", dv, 1);
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) @(negedge clk);
    check("run1_done", done, 1);
    check("run1_busy", busy, 0);
    check("run1_cycles", run_cycles, 100);
    check("run1_timeout", timeout_err, 0);
    check("run1_clr_once", clr_cnt - s_clr, 1);
    check("tm_writes", tm_cnt - s_tm, 8);
    check("tm_data", tm_bad - s_tmb, 0);
    check("tm_first_offset", tm_first - clr_cyc, 2);
    check("tm_back_to_back", tm_last - tm_first, 7);
    check("ic_writes", ic_cnt - s_ic, 4096);
    check("ic_data", ic_bad - s_icb, 0);
    check("ic_phase_len", ic_span - s_span, 4097);
    check("mem_writes", mem_cnt - s_mem, 256);
    check("mem_data", mem_bad - s_memb, 0);
    check("lat_writes", lat_cnt - s_lat, 256);
    check("lat_data", lat_bad - s_latb, 0);
    check("lat_255", lat255, 31);
    check("dump_count", dump_cnt - s_dmp, 256);
    check("dump_data", dump_bad - s_dmpb, 0);
    repeat (3) @(negedge clk);
    check("done_hold", {done, we_tm, ic_wen, memwrite, lat_we, dv, da}, {1'b1, 5'd0, 8'd255});

    // go in DONE restarts at CLR
    snap();
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("restart_clr", {clear_tm, done, busy}, 3'b101);
    @(negedge clk);
    check("restart_cleared", {timeout_err, run_cycles}, 0);
    check("restart_no_tm_c0", we_tm, 0);
    @(negedge clk);
    check("restart_tm_c1", {we_tm, wd_tm}, {1'b1, 29'h1000_0000});
    for (int i = 0; i < 8000 && !done; i++) @(negedge clk);
    check("run2_done", done, 1);
    check("run2_cycles", run_cycles, 100);
    check("run2_dump", dump_cnt - s_dmp, 256);

    // Timeout path on the second instance
    @(negedge clk) go2 = 1'b1;
    @(negedge clk) go2 = 1'b0;
    for (int i = 0; i < 3000 && !done2; i++) @(negedge clk);
    check("to_done", done2, 1);
    check("to_err", to2, 1);
    check("to_cycles", run2, 50);
    check("to_dump", dump2_cnt, 256);

    check("one_strobe", multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fio_init_sequencer.md
Name: fio_init_sequencer

Overview:
- Host-side FileIO sequencer directly upstream of gpu_top_checking; it drives every FIO/FileIO port of the GPU top.
- Reads a pre-built init image through a shared 1-cycle-latency read port, then streams it into the GPU in a fixed order: task manager, ICache, data memory, cache latency table.
- Pulses start, waits for finished_TM_FIO (with timeout), counts run cycles, then dumps data memory word-by-word on a valid-qualified output.

Parameters:
- MEM_SIZE, 256, data memory depth in 256-bit words
- SHMEM_SIZE, 256, shared memory depth; sets the FIO_ADDR width
- ICACHE_DEPTH, 4096, ICache words loaded
- TM_DEPTH, 8, task manager words loaded
- TIMEOUT_CYCLES, 1000000, maximum wait for finished_TM_FIO
- Derived: AW=$clog2(MEM_SIZE+SHMEM_SIZE), MAW=$clog2(MEM_SIZE)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- go  in  1  start sequence; sampled only in IDLE
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  high in DONE; cleared by the next accepted go
- timeout_err  out  1  set on timeout; cleared by the next accepted go
- run_cycles  out  32  cycle count from the start pulse to finished_TM_FIO
- img_rd_en  out  1  image read strobe
- img_sel  out  2  0=TM, 1=ICache, 2=MEM, 3=LAT
- img_addr  out  12  image word index
- img_rdata  in  256  image data, valid the cycle after img_rd_en
- Write_Enable_FIO_TM  out  1; Write_Data_FIO_TM  out  29
- start_FIO_TM  out  1; clear_FIO_TM  out  1; finished_TM_FIO  in  1
- FileIO_Wen_ICache  out  1; FileIO_Addr_ICache  out  12; FileIO_Din_ICache  out  32
- FIO_MEMWRITE  out  1; FIO_ADDR  out  AW; FIO_WRITE_DATA  out  256; FIO_READ_DATA  in  256
- FIO_CACHE_LAT_WRITE  out  1; FIO_CACHE_LAT_VALUE  out  5; FIO_CACHE_MEM_ADDR  out  MAW
- dump_valid  out  1; dump_addr  out  MAW; dump_data  out  256

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0 (including run_cycles, done and timeout_err); all counters 0. Reset mid-sequence aborts with no further GPU writes.
- States: IDLE -> CLR -> LD_TM -> LD_IC -> LD_MEM -> LD_LAT -> START -> WAIT -> DUMP -> DONE. go in DONE returns to CLR. go in any other non-IDLE state is ignored.
- CLR (1 cycle): clear_FIO_TM=1; done, timeout_err and run_cycles reset.
- Load phase of N words takes N+1 cycles:
  - Cycles 0..N-1: img_rd_en=1, img_sel=phase code, img_addr=i.
  - Cycles 1..N: write strobe=1, target address=i-1, data=img_rdata low bits (TM [28:0], ICache [31:0], MEM [255:0], LAT [4:0]).
  - No write in cycle 0; no read in cycle N.
  - N per phase: TM_DEPTH, ICACHE_DEPTH, MEM_SIZE, MEM_SIZE. MEM addresses are zero-extended to AW.
- Write strobes are single-cycle per word. Address and data outputs hold their last value when the strobe is low. Only one strobe is ever high at a time.
- START (1 cycle): start_FIO_TM=1; run_cycles cleared to 0.
- WAIT: run_cycles increments each cycle, saturating at 2^32-1.
  - finished_TM_FIO=1 -> DUMP; that cycle is not counted.
  - If run_cycles reaches TIMEOUT_CYCLES first: timeout_err=1 -> DUMP.
- DUMP: FIO_MEMWRITE=0 and FIO_ADDR=j for j=0..MEM_SIZE-1, one per cycle.
  - One cycle later: dump_valid=1, dump_addr=j, dump_data=FIO_READ_DATA.
  - The phase takes MEM_SIZE+1 cycles, then goes to DONE.
- DONE: done=1, busy=0. Outputs hold; strobes are 0.

Test Plan:
- Reset during LD_MEM (word 10) -> all strobes drop to 0 immediately; state IDLE; done=0; no further writes after rst releases.
- go with TM image words 0x1000_0000+i -> clear_FIO_TM pulse 1 cycle, then 8 Write_Enable_FIO_TM pulses with data 0x1000_0000..0x1000_0007 (29-bit truncated), back-to-back starting 1 cycle after LD_TM entry.
- Full load: ICache word k = k*3, LAT value = k&31 -> FileIO_Addr_ICache k sees 3k; FIO_CACHE_MEM_ADDR 255 gets 31; LD_IC lasts exactly 4097 cycles.
- Model raises finished_TM_FIO 100 cycles after start_FIO_TM -> run_cycles=100; timeout_err=0.
- finished_TM_FIO never rises with TIMEOUT_CYCLES=50 -> timeout_err=1 after 50 WAIT cycles; dump still runs; done=1.
- Dump with MEM echoing its address -> 256 dump_valid pulses, dump_data==dump_addr; go pulsed during DUMP is ignored; go in DONE restarts at CLR.
